// File: rtl/rv32_pkg.sv
// RV32I opcodes, instruction formats and the field bundle
// shared by the instruction decoder and the loader/encoder.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    unique case (1'b1)
      op == OP_R:      f = FMT_R;
      op == OP_IMM,
      op == OP_LOAD,
      op == OP_JALR:   f = FMT_I;
      op == OP_STORE:  f = FMT_S;
      op == OP_BRANCH: f = FMT_B;
      op == OP_LUI,
      op == OP_AUIPC:  f = FMT_U;
      op == OP_JAL:    f = FMT_J;
      default:         f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: field bundle -> 32-bit RV32I word.
// fmt_bad flags an unknown opcode or an odd B/J offset.
module instr_pack
  import rv32_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        fmt_bad
);

  // Select the bit layout by instruction format
  always_comb begin
    word    = '0;
    fmt_bad = 1'b0;
    unique case (fmt_of(f.opcode))
      FMT_R: word = {f.funct7, f.rs2, f.rs1,
                     f.funct3, f.rd, f.opcode};
      FMT_I: word = {f.imm[11:0], f.rs1,
                     f.funct3, f.rd, f.opcode};
      FMT_S: word = {f.imm[11:5], f.rs2, f.rs1,
                     f.funct3, f.imm[4:0], f.opcode};
      FMT_B: begin
        word = {f.imm[12], f.imm[10:5], f.rs2,
                f.rs1, f.funct3, f.imm[4:1],
                f.imm[11], f.opcode};
        fmt_bad = f.imm[0];
      end
      FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: begin
        word = {f.imm[20], f.imm[10:1], f.imm[11],
                f.imm[19:12], f.rd, f.opcode};
        fmt_bad = f.imm[0];
      end
      default: fmt_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test loader: encodes RV32I field bundles and
// writes them sequentially into IMEM.
module instr_encoder_loader
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e      state;
  fields_t     f;
  logic [31:0] word;
  logic        bad;
  logic        accept;
  logic [CW-1:0] cnt_inc;

  assign f = '{opcode: opcode, rd: rd,
               funct3: funct3, rs1: rs1,
               rs2: rs2, funct7: funct7,
               imm: imm};

  instr_pack u_pack (
    .f       (f),
    .word    (word),
    .fmt_bad (bad)
  );

  // Count and write strobe advance on the same
  // edge, so no write is ever outstanding here.
  assign in_ready = (state == LOAD)
                  && (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = count + CW'(1);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  // Session FSM with registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      imem_wdata <= '0;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            count <= '0;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (!bad) begin
              imem_we    <= 1'b1;
              imem_addr  <= ADDR_W'(BASE_ADDR)
                          + ADDR_W'({count, 2'b00});
              imem_wdata <= word;
              count      <= cnt_inc;
            end else begin
              err <= 1'b1;
            end
            if (in_last ||
                (!bad && cnt_inc == CW'(DEPTH)))
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed steps plus
// random bundles against a behavioural reference model.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_s;
  logic        in_valid, valid_s, in_last;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic        ready0, we0, busy0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic [8:0]  count0;
  logic        ready1, we1, busy1, done1, err1;
  logic [31:0] addr1, wdata1;
  logic [2:0]  count1;

  instr_encoder_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(ready0),
    .in_last(in_last), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm),
    .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wdata0), .busy(busy0),
    .done(done0), .err(err0), .count(count0)
  );

  instr_encoder_loader #(.DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .in_valid(valid_s), .in_ready(ready1),
    .in_last(in_last), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm),
    .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wdata1), .busy(busy1),
    .done(done1), .err(err1), .count(count1)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // reference model: 0 idle, 1 load, 2 done
  int          m_st[2];
  int          m_cnt[2];
  int          m_err[2];
  int          m_we[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd[2];
  int          depth[2] = '{256, 4};
  int          wr1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(
    input int op, input int d, input int f3,
    input int s1, input int s2, input int f7,
    input logic [31:0] im, output bit bad);
    logic [31:0] w;
    bad = 0;
    w = 32'(op) | 32'(d) << 7;
    case (op)
      'h33:
        w = 32'(op) | 32'(d) << 7 | 32'(f3) << 12
          | 32'(s1) << 15 | 32'(s2) << 20
          | 32'(f7) << 25;
      'h13, 'h03, 'h67:
        w = w | 32'(f3) << 12 | 32'(s1) << 15
          | (im & 32'hfff) << 20;
      'h23:
        w = 32'(op) | (im & 32'h1f) << 7
          | 32'(f3) << 12 | 32'(s1) << 15
          | 32'(s2) << 20 | ((im >> 5) & 32'h7f) << 25;
      'h63: begin
        w = 32'(op) | ((im >> 11) & 1) << 7
          | ((im >> 1) & 32'hf) << 8
          | 32'(f3) << 12 | 32'(s1) << 15
          | 32'(s2) << 20 | ((im >> 5) & 32'h3f) << 25
          | ((im >> 12) & 1) << 31;
        bad = im[0];
      end
      'h37, 'h17:
        w = w | (im & 32'hfffff000);
      'h6f: begin
        w = w | ((im >> 12) & 32'hff) << 12
          | ((im >> 11) & 1) << 20
          | ((im >> 1) & 32'h3ff) << 21
          | ((im >> 20) & 1) << 31;
        bad = im[0];
      end
      default: bad = 1;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
      m_we[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
    end
  endtask

  task automatic model_step(input int i,
                            input bit st,
                            input bit v);
    bit bad;
    bit acc;
    logic [31:0] w;
    acc = v && m_st[i] == 1 && m_cnt[i] < depth[i];
    m_we[i] = 0;
    if (m_st[i] != 1 && st) begin
      m_st[i] = 1; m_cnt[i] = 0; m_err[i] = 0;
    end else if (acc) begin
      w = enc(opcode, rd, funct3, rs1, rs2,
              funct7, imm, bad);
      if (!bad) begin
        m_we[i] = 1;
        m_addr[i] = 32'(4 * m_cnt[i]);
        m_wd[i] = w;
        m_cnt[i]++;
      end else m_err[i] = 1;
      if (in_last || m_cnt[i] == depth[i])
        m_st[i] = 2;
    end
  endtask

  task automatic check_all(input int i);
    string p;
    p = (i == 0) ? "big" : "small";
    if (i == 0) begin
      chk({p, " we"}, 32'(we0), 32'(m_we[0]));
      chk({p, " busy"}, 32'(busy0), 32'(m_st[0] == 1));
      chk({p, " done"}, 32'(done0), 32'(m_st[0] == 2));
      chk({p, " err"}, 32'(err0), 32'(m_err[0]));
      chk({p, " count"}, 32'(count0), 32'(m_cnt[0]));
      chk({p, " ready"}, 32'(ready0),
          32'(m_st[0] == 1 && m_cnt[0] < depth[0]));
      if (m_we[0] != 0) begin
        chk({p, " addr"}, addr0, m_addr[0]);
        chk({p, " wdata"}, wdata0, m_wd[0]);
      end
    end else begin
      chk({p, " we"}, 32'(we1), 32'(m_we[1]));
      chk({p, " busy"}, 32'(busy1), 32'(m_st[1] == 1));
      chk({p, " done"}, 32'(done1), 32'(m_st[1] == 2));
      chk({p, " err"}, 32'(err1), 32'(m_err[1]));
      chk({p, " count"}, 32'(count1), 32'(m_cnt[1]));
      chk({p, " ready"}, 32'(ready1),
          32'(m_st[1] == 1 && m_cnt[1] < depth[1]));
      if (m_we[1] != 0) begin
        chk({p, " addr"}, addr1, m_addr[1]);
        chk({p, " wdata"}, wdata1, m_wd[1]);
      end
    end
  endtask

  task automatic step(input bit s0, input bit v0,
                      input bit s1, input bit v1,
                      input bit last);
    start = s0; in_valid = v0;
    start_s = s1; valid_s = v1; in_last = last;
    model_step(0, s0, v0);
    model_step(1, s1, v1);
    @(posedge clk);
    #1;
    if (we1) wr1++;
    check_all(0);
    check_all(1);
  endtask

  task automatic setf(input int op, input int d,
                      input int f3, input int s1,
                      input int s2, input int f7,
                      input logic [31:0] im);
    opcode = 7'(op); rd = 5'(d); funct3 = 3'(f3);
    rs1 = 5'(s1); rs2 = 5'(s2); funct7 = 7'(f7);
    imm = im;
  endtask

  task automatic chk_reset();
    chk("rst we", 32'(we0), 0);
    chk("rst addr", addr0, 0);
    chk("rst wdata", wdata0, 0);
    chk("rst busy", 32'(busy0), 0);
    chk("rst done", 32'(done0), 0);
    chk("rst err", 32'(err0), 0);
    chk("rst count", 32'(count0), 0);
    chk("rst ready", 32'(ready0), 0);
    chk("rst small we", 32'(we1), 0);
    chk("rst small count", 32'(count1), 0);
  endtask

  int ops[11] = '{'h33, 'h13, 'h03, 'h67, 'h23,
                  'h63, 'h37, 'h17, 'h6f, 'h7f, 'h00};

  initial begin
    rst_n = 0; start = 0; start_s = 0;
    in_valid = 0; valid_s = 0; in_last = 0;
    wr1 = 0;
    setf(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk_reset();
    rst_n = 1;
    @(posedge clk); #1;

    // session: ADD, ADDI, SW, BEQ, LUI(last)
    step(1, 0, 0, 0, 0);
    setf('h33, 3, 0, 1, 2, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("add word", wdata0, 32'h002081B3);
    chk("add addr", addr0, 32'h0);
    setf('h13, 1, 0, 0, 0, 0, 5);
    step(0, 1, 0, 0, 0);
    chk("addi word", wdata0, 32'h00500093);
    chk("addi addr", addr0, 32'h4);
    setf('h23, 0, 2, 1, 2, 0, 8);
    step(0, 1, 0, 0, 0);
    chk("sw word", wdata0, 32'h0020A423);
    chk("sw addr", addr0, 32'h8);
    chk("count3", 32'(count0), 3);
    setf('h63, 0, 0, 1, 2, 0, 8);
    step(0, 1, 0, 0, 0);
    chk("beq word", wdata0, 32'h00208463);
    setf('h37, 5, 0, 0, 0, 0, 32'h12345000);
    step(0, 1, 0, 0, 1);
    chk("lui word", wdata0, 32'h123452B7);
    chk("lui done", 32'(done0), 1);
    chk("lui busy", 32'(busy0), 0);
    step(0, 1, 0, 0, 0);

    // errors: odd branch, bad opcode, then legal
    step(1, 0, 0, 0, 0);
    setf('h63, 0, 0, 1, 2, 0, 3);
    step(0, 1, 0, 0, 0);
    chk("beq odd we", 32'(we0), 0);
    chk("beq odd err", 32'(err0), 1);
    setf('h7f, 1, 1, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("bad op cnt", 32'(count0), 0);
    setf('h33, 3, 0, 1, 2, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("after err we", 32'(we0), 1);
    chk("err sticky", 32'(err0), 1);

    // small instance fills at DEPTH=4
    step(0, 0, 1, 0, 0);
    wr1 = 0;
    for (int k = 0; k < 6; k++) begin
      setf('h33, k + 1, 0, k, k + 2, 0, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("full writes", 32'(wr1), 4);
    chk("full count", 32'(count1), 4);
    chk("full done", 32'(done1), 1);
    chk("full ready", 32'(ready1), 0);

    // async reset with a write in flight
    step(1, 0, 0, 0, 0);
    setf('h13, 2, 0, 1, 0, 0, 7);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_reset();
    #2 rst_n = 1;
    step(1, 0, 0, 0, 0);
    setf('h33, 3, 0, 1, 2, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("restart addr", addr0, 32'h0);

    // random bundles on both instances
    for (int k = 0; k < 400; k++) begin
      setf(ops[$urandom_range(10)], $urandom,
           $urandom, $urandom, $urandom,
           $urandom, $urandom);
      step($urandom_range(7) == 0,
           $urandom_range(3) != 0,
           $urandom_range(7) == 0,
           $urandom_range(3) != 0,
           $urandom_range(9) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
